fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000, address of first fetch after reset.
REQ-002 Parameter NOP_WORD, 16'h0000, instruction value driven when the IF/ID output holds no valid word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode cannot accept a new word; IF/ID register holds.
REQ-006 redirect  input  1  taken branch/jump; fetch restarts at redirect_pc.
REQ-007 redirect_pc  input  16  word address of the redirect target.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  16  word address of the current request.
REQ-010 imem_ack  input  1  memory returns data this cycle; transfer = imem_req && imem_ack.
REQ-011 imem_data  input  16  instruction word, valid only on a transfer.
REQ-012 instruction  output  16  IF/ID instruction word, consumed by the decoding stage.
REQ-013 pc_out  output  16  word address of instruction.
REQ-014 valid  output  1  instruction/pc_out hold a real fetched word.

Function
REQ-015 State machine SHALL have three states: FETCH, HOLD, DRAIN.
REQ-016 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD; imem_addr SHALL equal pc register in FETCH and stay stable until transfer.
REQ-017 Once raised, imem_req and imem_addr SHALL not change until a transfer occurs (no request withdrawal).
REQ-018 FETCH, transfer, !stall, !redirect: IF/ID <= {imem_data, pc, valid=1}; pc <= pc+1; stay FETCH.
REQ-019 FETCH, transfer, stall, !redirect: word and its pc captured in skid register; pc <= pc+1; go HOLD.
REQ-020 FETCH, no transfer, !stall: IF/ID loads bubble {NOP_WORD, pc_out unchanged, valid=0}.
REQ-021 Any state, stall && !redirect: IF/ID SHALL hold its contents exactly.
REQ-022 HOLD, !stall, !redirect: IF/ID <= skid contents with valid=1; go FETCH next cycle (one-cycle request gap).
REQ-023 Latency: data accepted at edge N with !stall SHALL appear on instruction/valid immediately after edge N.
REQ-024 pc increment SHALL be modulo 2^16: 16'hFFFF -> 16'h0000.
REQ-025 redirect SHALL have priority over stall and over any transfer in the same cycle; the transferred word is discarded.
REQ-026 redirect in FETCH with transfer, or in HOLD: pc <= redirect_pc, skid discarded, IF/ID valid <= 0 and instruction <= NOP_WORD, next state FETCH.
REQ-027 redirect in FETCH without transfer: redirect_pc saved in target register, IF/ID invalidated, go DRAIN.
REQ-028 DRAIN: request kept stable; on transfer data discarded, pc <= saved target, go FETCH; a new redirect in DRAIN overwrites the saved target.
REQ-029 Stall has no effect on state while in DRAIN; IF/ID stays invalid throughout DRAIN.
REQ-030 No word SHALL ever be duplicated or dropped except as stated for redirect.

Reset
REQ-031 While reset is low: state=FETCH, pc=RESET_PC, imem_req=0, instruction=NOP_WORD, pc_out=16'h0000, valid=0, skid and target cleared.
REQ-032 imem_req SHALL first assert in the cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-033 Reset asserted mid-request or in HOLD/DRAIN SHALL abort immediately; the outstanding word is dropped.

Verification
REQ-034 Memory acks every cycle, data=addr+16'hA000, no stall -> valid=1 every cycle from second edge, pc_out 0,1,2,..., instruction A000,A001,...
REQ-035 Ack on word 5 with stall=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID holds word 4; stall drops -> instruction=A005, pc_out=5, next request addr 6.
REQ-036 redirect=1, redirect_pc=16'h0040 with ack same cycle -> that word discarded, valid=0 next cycle, next request addr 0040.
REQ-037 redirect to 16'h0080 while request to 0x10 waits 3 cycles for ack -> addr 0x10 held, valid=0 throughout, after ack next request addr 0080.
REQ-038 pc=16'hFFFF, ack -> pc_out=FFFF valid=1, next imem_addr=0000.
REQ-039 Reset low during HOLD -> all outputs at REQ-031 values asynchronously; after release first request at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word reads to instruction memory and feeds the IF/ID register,
// with a one-entry skid for stalls and a drain state so an outstanding request is never withdrawn.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   output logic [15:0] instruction,
   output logic [15:0] pc_out,
   output logic        valid
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] pc;
   logic [15:0] skid_instr;
   logic [15:0] skid_pc;
   logic [15:0] target;
   logic        req_q;
   logic        transfer;

   assign imem_req  = req_q;
   assign imem_addr = pc;
   assign transfer  = req_q & imem_ack;

   // req_q is registered so it stays low throughout reset and first rises one edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         req_q       <= 1'b0;
         instruction <= NOP_WORD;
         pc_out      <= '0;
         valid       <= 1'b0;
         skid_instr  <= '0;
         skid_pc     <= '0;
         target      <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  instruction <= NOP_WORD;
                  valid       <= 1'b0;
                  req_q       <= 1'b1;
                  // With nothing outstanding (transfer done or no request raised) jump directly.
                  if (transfer || !req_q) begin
                     pc    <= redirect_pc;
                     state <= FETCH;
                  end else begin
                     target <= redirect_pc;
                     state  <= DRAIN;
                  end
               end else if (transfer) begin
                  pc <= pc + 16'd1;
                  if (stall) begin
                     skid_instr <= imem_data;
                     skid_pc    <= pc;
                     req_q      <= 1'b0;
                     state      <= HOLD;
                  end else begin
                     instruction <= imem_data;
                     pc_out      <= pc;
                     valid       <= 1'b1;
                     req_q       <= 1'b1;
                     state       <= FETCH;
                  end
               end else begin
                  req_q <= 1'b1;
                  state <= FETCH;
                  if (!stall) begin
                     instruction <= NOP_WORD;
                     valid       <= 1'b0;
                  end
               end
            end

            HOLD: begin
               if (redirect) begin
                  pc          <= redirect_pc;
                  skid_instr  <= '0;
                  skid_pc     <= '0;
                  instruction <= NOP_WORD;
                  valid       <= 1'b0;
                  req_q       <= 1'b1;
                  state       <= FETCH;
               end else if (!stall) begin
                  instruction <= skid_instr;
                  pc_out      <= skid_pc;
                  valid       <= 1'b1;
                  skid_instr  <= '0;
                  skid_pc     <= '0;
                  req_q       <= 1'b1;
                  state       <= FETCH;
               end else begin
                  req_q <= 1'b0;
                  state <= HOLD;
               end
            end

            DRAIN: begin
               instruction <= NOP_WORD;
               valid       <= 1'b0;
               req_q       <= 1'b1;
               if (redirect) begin
                  target <= redirect_pc;
               end
               if (transfer) begin
                  pc    <= redirect ? redirect_pc : target;
                  state <= FETCH;
               end else begin
                  state <= DRAIN;
               end
            end

            default: begin
               req_q <= 1'b0;
               state <= FETCH;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // A raised request must keep its address until memory accepts it.
   req_stable: assert property (@(posedge clk) disable iff (!reset)
      (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr+16'hA000, each task checks
// {imem_req, imem_addr, valid, pc_out, instruction} after every rising edge.
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'h1357;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data;
   logic [15:0] instruction;
   logic [15:0] pc_out;
   logic        valid;

   int unsigned total = 0;
   int unsigned bad = 0;

   logic [49:0] obs;
   logic [49:0] exp_v;

   fetch_stage #(.RESET_PC(16'h0000), .NOP_WORD(NOP)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_data(imem_data),
      .instruction(instruction),
      .pc_out(pc_out),
      .valid(valid)
   );

   always #5 clk = ~clk;

   assign imem_data = imem_addr + 16'hA000;
   assign obs = {imem_req, imem_addr, valid, pc_out, instruction};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time=%0t required < 200000", $time);
      $fatal(1);
   end

   // Advance through one rising edge and land on the following falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
      cyc(); cyc();
      exp_v = {1'b0, 16'h0000, 1'b0, 16'h0000, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL reset_state: got %h required %h", obs, exp_v);
      end
      reset = 1'b1; imem_ack = 1'b1;
      cyc();
      exp_v = {1'b1, 16'h0000, 1'b0, 16'h0000, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL first_request: got %h required %h", obs, exp_v);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 5; i++) begin
         cyc();
         exp_v = {1'b1, 16'(i + 1), 1'b1, 16'(i), 16'hA000 + 16'(i)};
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL stream_word%0d: got %h required %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_stall_hold();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         exp_v = {1'b0, 16'h0006, 1'b1, 16'h0004, 16'hA004};
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL hold_cycle%0d: got %h required %h", i, obs, exp_v);
         end
      end
      stall = 1'b0;
      cyc();
      exp_v = {1'b1, 16'h0006, 1'b1, 16'h0005, 16'hA005};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL hold_release: got %h required %h", obs, exp_v);
      end
      cyc();
      exp_v = {1'b1, 16'h0007, 1'b1, 16'h0006, 16'hA006};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL after_hold: got %h required %h", obs, exp_v);
      end
   endtask

   task automatic test_redirect_ack();
      redirect = 1'b1; redirect_pc = 16'h0040;
      cyc();
      exp_v = {1'b1, 16'h0040, 1'b0, 16'h0006, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL redirect_discard: got %h required %h", obs, exp_v);
      end
      redirect = 1'b0;
      cyc();
      exp_v = {1'b1, 16'h0041, 1'b1, 16'h0040, 16'hA040};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL redirect_target_word: got %h required %h", obs, exp_v);
      end
      redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0050;
      cyc();
      exp_v = {1'b1, 16'h0050, 1'b0, 16'h0040, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL redirect_over_stall: got %h required %h", obs, exp_v);
      end
      redirect = 1'b0; stall = 1'b0;
      cyc();
      exp_v = {1'b1, 16'h0051, 1'b1, 16'h0050, 16'hA050};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL redirect_stall_word: got %h required %h", obs, exp_v);
      end
   endtask

   task automatic test_redirect_drain();
      redirect = 1'b1; redirect_pc = 16'h0010;
      cyc();
      redirect = 1'b0; imem_ack = 1'b0;
      cyc();
      exp_v = {1'b1, 16'h0010, 1'b0, 16'h0050, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL wait_bubble: got %h required %h", obs, exp_v);
      end
      redirect = 1'b1; redirect_pc = 16'h0080;
      for (int i = 0; i < 3; i++) begin
         cyc();
         redirect = 1'b0;
         stall = (i == 0);
         exp_v = {1'b1, 16'h0010, 1'b0, 16'h0050, NOP};
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL drain_wait%0d: got %h required %h", i, obs, exp_v);
         end
      end
      stall = 1'b0; imem_ack = 1'b1;
      cyc();
      exp_v = {1'b1, 16'h0080, 1'b0, 16'h0050, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL drain_exit: got %h required %h", obs, exp_v);
      end
      cyc();
      exp_v = {1'b1, 16'h0081, 1'b1, 16'h0080, 16'hA080};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL drain_target_word: got %h required %h", obs, exp_v);
      end
      imem_ack = 1'b0;
      cyc();
      redirect = 1'b1; redirect_pc = 16'h00C0;
      cyc();
      redirect_pc = 16'h00D0;
      cyc();
      redirect = 1'b0; imem_ack = 1'b1;
      cyc();
      exp_v = {1'b1, 16'h00D0, 1'b0, 16'h0080, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL drain_overwrite: got %h required %h", obs, exp_v);
      end
      cyc();
      exp_v = {1'b1, 16'h00D1, 1'b1, 16'h00D0, 16'hA0D0};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL overwrite_word: got %h required %h", obs, exp_v);
      end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      cyc();
      redirect = 1'b0;
      cyc();
      exp_v = {1'b1, 16'h0000, 1'b1, 16'hFFFF, 16'h9FFF};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL wrap_top: got %h required %h", obs, exp_v);
      end
      cyc();
      exp_v = {1'b1, 16'h0001, 1'b1, 16'h0000, 16'hA000};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL wrap_zero: got %h required %h", obs, exp_v);
      end
   endtask

   task automatic test_hold_reset();
      stall = 1'b1;
      cyc();
      exp_v = {1'b0, 16'h0002, 1'b1, 16'h0000, 16'hA000};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL enter_hold: got %h required %h", obs, exp_v);
      end
      #2 reset = 1'b0;
      #1;
      exp_v = {1'b0, 16'h0000, 1'b0, 16'h0000, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL async_reset: got %h required %h", obs, exp_v);
      end
      cyc(); cyc();
      reset = 1'b1; stall = 1'b0;
      cyc();
      exp_v = {1'b1, 16'h0000, 1'b0, 16'h0000, NOP};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL post_reset_request: got %h required %h", obs, exp_v);
      end
      cyc();
      exp_v = {1'b1, 16'h0001, 1'b1, 16'h0000, 16'hA000};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL post_reset_word: got %h required %h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_hold();
      test_redirect_ack();
      test_redirect_drain();
      test_wrap();
      test_hold_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
